sep_slot_tracker: RTL

Parametrised successor to the fixed 32-slot operator counter. It tracks the current operator slot, decodes the slot into channel and operator indices, and emits a wrap strobe. It also supervises the external zero/sync pulse and reports lock state, sync errors and a saturating error count. It sits next to the operator pipeline and provides slot and sync status to the envelope, phase and debug logic.

---
 rtl/sep_slot_tracker.sv | 104 ++++++++++
 1 files changed

// File: rtl/sep_slot_tracker.sv
// Operator slot counter with channel/operator decode, wrap strobe and
// zero/sync supervision (lock tracking, lock-loss pulse, saturating error count).
module sep_slot_tracker #(
    parameter int SLOTS    = 32,
    parameter int OPS      = 4,
    parameter int W        = 5,
    parameter int CHW      = 3,
    parameter int OPW      = 2,
    parameter int ZERO_VAL = 1,
    parameter int LOCK_N   = 2,
    parameter int MISS_MAX = 2,
    parameter int EW       = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    input  logic           zero,
    output logic [W-1:0]   cnt,
    output logic [CHW-1:0] ch,
    output logic [OPW-1:0] op,
    output logic           wrap,
    output logic           locked,
    output logic           sync_err,
    output logic [EW-1:0]  err_cnt
);

    localparam int CH = SLOTS / OPS;

    logic [W-1:0] cnt_nxt;
    logic [3:0]   match_cnt;
    logic [3:0]   miss_cnt;
    logic [3:0]   match_inc;
    logic [3:0]   miss_inc;
    logic         last;
    logic         in_phase;

    function automatic logic [EW-1:0] sat_inc(input logic [EW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign last      = (cnt == W'(SLOTS - 1));
    assign in_phase  = (cnt == '0);
    // A realigning (out-of-phase) zero counts as the first match of a new run.
    assign match_inc = in_phase ? match_cnt + 4'd1 : 4'd1;
    assign miss_inc  = miss_cnt + 4'd1;

    always_comb begin
        cnt_nxt = cnt;
        if (zero)
            cnt_nxt = W'(ZERO_VAL);
        else if (cen)
            cnt_nxt = last ? '0 : cnt + 1'b1;
    end

    // ch/op are decoded from the next count so they never lag cnt.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            ch        <= '0;
            op        <= '0;
            wrap      <= 1'b0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            err_cnt   <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else begin
            cnt      <= cnt_nxt;
            ch       <= CHW'(int'(cnt_nxt) % CH);
            op       <= OPW'(int'(cnt_nxt) / CH);
            wrap     <= 1'b0;
            sync_err <= 1'b0;
            if (zero) begin
                miss_cnt <= '0;
                if (locked) begin
                    if (!in_phase) begin
                        locked    <= 1'b0;
                        sync_err  <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        match_cnt <= 4'd1;
                    end
                end else begin
                    match_cnt <= match_inc;
                    if (match_inc >= 4'(LOCK_N))
                        locked <= 1'b1;
                end
            end else if (cen && last) begin
                wrap <= 1'b1;
                if (locked) begin
                    if (miss_inc >= 4'(MISS_MAX)) begin
                        locked    <= 1'b0;
                        sync_err  <= 1'b1;
                        err_cnt   <= sat_inc(err_cnt);
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end else begin
                        miss_cnt <= miss_inc;
                    end
                end
            end
        end
    end

endmodule
